// File: rtl/timing_align.sv
// Automatic delay-tap selection: sweeps delay_change over four taps, picks the
// tap with least sum-of-absolute-error vs sig_ref. Option: TIMING_ALIGN_TRACK_EN.
module timing_align #(
    parameter int LOG2_N = 8,
    parameter int SETTLE = 2,
    parameter int ACC_W  = 18 + LOG2_N
) (
    input  logic                sys_clk,
    input  logic                reset,
    input  logic                sam_clk_en,
    input  logic                start,
    input  logic signed [17:0]  sig_ref,
    input  logic signed [17:0]  sig_dut,
    output logic [1:0]          delay_change,
    output logic                busy,
    output logic                locked,
    output logic [ACC_W-1:0]    best_err
);

    localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_ACCUM,
        ST_COMPARE,
        ST_DONE
    } state_t;

    // A zero settle count goes straight to accumulation.
    localparam state_t FIRST_ST = (SETTLE == 0) ? ST_ACCUM : ST_SETTLE;

    state_t             state, state_nxt;
    logic [1:0]         cand, cand_nxt;
    logic [1:0]         best_idx, best_idx_nxt;
    logic [SC_W-1:0]    settle_cnt, settle_cnt_nxt;
    logic [LOG2_N-1:0]  sample_cnt, sample_cnt_nxt;
    logic [ACC_W-1:0]   acc, acc_nxt;
    logic [ACC_W-1:0]   best_err_nxt;
    logic [1:0]         delay_change_nxt;
    logic               busy_nxt, locked_nxt;

    logic signed [18:0] diff;
    logic [18:0]        diff_neg;
    logic [17:0]        mag;
    logic [ACC_W-1:0]   acc_sum;
    logic               settle_last, sample_last;
    logic               take;
    logic               launch;

    always_comb begin
        diff     = {sig_ref[17], sig_ref} - {sig_dut[17], sig_dut};
        diff_neg = -diff;
        mag      = diff[18] ? diff_neg[17:0] : diff[17:0];
        acc_sum  = acc + ACC_W'(mag);
    end

    assign settle_last = (settle_cnt == SC_W'(SETTLE - 1));
    assign sample_last = (sample_cnt == '1);
    assign take        = (cand == 2'd0) || (acc < best_err);

`ifdef TIMING_ALIGN_TRACK_EN
    logic [ACC_W+1:0] track_limit;
    logic             track_fail;
    assign track_limit = {1'b0, best_err, 1'b0} + ((ACC_W + 2)'(1) << LOG2_N);
    assign track_fail  = ((ACC_W + 2)'(acc_sum) > track_limit);
`endif

    always_comb begin
        state_nxt        = state;
        cand_nxt         = cand;
        best_idx_nxt     = best_idx;
        settle_cnt_nxt   = settle_cnt;
        sample_cnt_nxt   = sample_cnt;
        acc_nxt          = acc;
        best_err_nxt     = best_err;
        delay_change_nxt = delay_change;
        busy_nxt         = busy;
        locked_nxt       = locked;
        launch           = 1'b0;

        case (state)
            ST_IDLE: begin
                busy_nxt = 1'b0;
                if (start) launch = 1'b1;
            end

            ST_SETTLE: begin
                if (sam_clk_en) begin
                    if (settle_last) begin
                        state_nxt      = ST_ACCUM;
                        sample_cnt_nxt = '0;
                    end else begin
                        settle_cnt_nxt = settle_cnt + 1'b1;
                    end
                end
            end

            ST_ACCUM: begin
                if (sam_clk_en) begin
                    acc_nxt        = acc_sum;
                    sample_cnt_nxt = sample_cnt + 1'b1;
                    if (sample_last) state_nxt = ST_COMPARE;
                end
            end

            ST_COMPARE: begin
                // Strobes landing here are ignored; the next settle window covers them.
                if (take) begin
                    best_err_nxt = acc;
                    best_idx_nxt = cand;
                end
                acc_nxt        = '0;
                settle_cnt_nxt = '0;
                sample_cnt_nxt = '0;
                if (cand == 2'd3) begin
                    state_nxt        = ST_DONE;
                    busy_nxt         = 1'b0;
                    locked_nxt       = 1'b1;
                    delay_change_nxt = take ? cand : best_idx;
                end else begin
                    state_nxt        = FIRST_ST;
                    cand_nxt         = cand + 1'b1;
                    delay_change_nxt = cand + 1'b1;
                end
            end

            ST_DONE: begin
                if (start) begin
                    launch = 1'b1;
                end
`ifdef TIMING_ALIGN_TRACK_EN
                else if (sam_clk_en) begin
                    acc_nxt        = acc_sum;
                    sample_cnt_nxt = sample_cnt + 1'b1;
                    if (sample_last) begin
                        if (track_fail) launch = 1'b1;
                        else            acc_nxt = '0;
                    end
                end
`endif
            end

            default: state_nxt = ST_IDLE;
        endcase

        if (launch) begin
            state_nxt        = FIRST_ST;
            cand_nxt         = '0;
            delay_change_nxt = '0;
            settle_cnt_nxt   = '0;
            sample_cnt_nxt   = '0;
            acc_nxt          = '0;
            busy_nxt         = 1'b1;
            locked_nxt       = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            cand         <= '0;
            best_idx     <= '0;
            settle_cnt   <= '0;
            sample_cnt   <= '0;
            acc          <= '0;
            best_err     <= '0;
            delay_change <= '0;
            busy         <= 1'b0;
            locked       <= 1'b0;
        end else begin
            state        <= state_nxt;
            cand         <= cand_nxt;
            best_idx     <= best_idx_nxt;
            settle_cnt   <= settle_cnt_nxt;
            sample_cnt   <= sample_cnt_nxt;
            acc          <= acc_nxt;
            best_err     <= best_err_nxt;
            delay_change <= delay_change_nxt;
            busy         <= busy_nxt;
            locked       <= locked_nxt;
        end
    end

endmodule

// File: tb/tb_timing_align.sv
// Directed bench for timing_align: bench-side 4-tap delay line, scoreboard of
// expected (tap, error) pushed at start and popped at lock.
module tb_timing_align;

    localparam int LOG2_N = 8;
    localparam int SETTLE = 2;
    localparam int ACC_W  = 18 + LOG2_N;
    localparam int N      = 1 << LOG2_N;
    localparam int SWEEP  = 4 * (SETTLE + N);

    logic               sys_clk = 1'b0;
    logic               reset;
    logic               sam_clk_en;
    logic               start;
    logic signed [17:0] sig_ref;
    logic signed [17:0] sig_dut;
    logic [1:0]         delay_change;
    logic               busy;
    logic               locked;
    logic [ACC_W-1:0]   best_err;

    logic signed [17:0] hist [0:3];
    logic [1:0]         ref_delay;
    logic signed [17:0] ref_offset;
    bit                 const_mode;

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;

    typedef struct {
        logic [1:0]       dc;
        logic [ACC_W-1:0] err;
    } exp_t;
    exp_t sb [$];

    always #5 sys_clk = ~sys_clk;

    assign sig_dut = hist[delay_change];
    assign sig_ref = hist[ref_delay] + ref_offset;

    timing_align #(
        .LOG2_N (LOG2_N),
        .SETTLE (SETTLE)
    ) dut (
        .sys_clk      (sys_clk),
        .reset        (reset),
        .sam_clk_en   (sam_clk_en),
        .start        (start),
        .sig_ref      (sig_ref),
        .sig_dut      (sig_dut),
        .delay_change (delay_change),
        .busy         (busy),
        .locked       (locked),
        .best_err     (best_err)
    );

    always @(posedge sys_clk) if (sam_clk_en) strobe_cnt <= strobe_cnt + 1;

    // Sample strobe every 4 clocks; a new x enters the delay line with each strobe.
    initial begin
        logic signed [17:0] rnd;
        sam_clk_en = 1'b0;
        for (int i = 0; i < 4; i++) hist[i] = '0;
        forever begin
            @(negedge sys_clk);
            sam_clk_en = 1'b0;
            repeat (3) @(negedge sys_clk);
            hist[3] = hist[2];
            hist[2] = hist[1];
            hist[1] = hist[0];
            rnd = 18'($urandom_range(0, 65535));
            hist[0] = const_mode ? 18'sd100 : (rnd - 18'sd32768);
            sam_clk_en = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge sys_clk);
        reset = 1'b0;
    endtask

    task automatic pulse_start(output int s0);
        @(negedge sys_clk);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        s0 = strobe_cnt;
    endtask

    task automatic wait_lock(input string tag, input int s0, input bit chk_len);
        int   n;
        exp_t e;
        n = 0;
        while (!locked && n < 20000) begin
            @(negedge sys_clk);
            n++;
        end
        if (!locked) check({tag, "_lock_timeout"}, 64'(locked), 64'd1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_delay_change"}, 64'(delay_change), 64'(e.dc));
            check({tag, "_best_err"}, 64'(best_err), 64'(e.err));
            check({tag, "_busy_done"}, 64'(busy), 64'd0);
            if (chk_len) check({tag, "_strobes"}, 64'(strobe_cnt - s0), 64'(SWEEP));
        end
    endtask

    task automatic run_sweep(input string tag, input logic [1:0] dc, input logic [ACC_W-1:0] err);
        exp_t e;
        int   s0;
        e.dc  = dc;
        e.err = err;
        sb.push_back(e);
        pulse_start(s0);
        check({tag, "_busy_start"}, 64'(busy), 64'd1);
        check({tag, "_locked_start"}, 64'(locked), 64'd0);
        check({tag, "_dc_start"}, 64'(delay_change), 64'd0);
        wait_lock(tag, s0, 1'b1);
    endtask

    task automatic wait_strobes(input string tag, input int s0, input int cnt);
        int n;
        n = 0;
        while ((strobe_cnt - s0) < cnt && n < 20000) begin
            @(negedge sys_clk);
            n++;
        end
        if ((strobe_cnt - s0) < cnt) check({tag, "_strobe_timeout"}, 64'(strobe_cnt - s0), 64'(cnt));
    endtask

    initial begin
        int s0;
        reset      = 1'b1;
        start      = 1'b0;
        ref_delay  = 2'd2;
        ref_offset = '0;
        const_mode = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("rst_delay_change", 64'(delay_change), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_locked", 64'(locked), 64'd0);
        check("rst_best_err", 64'(best_err), 64'd0);
        reset = 1'b0;

        // Reference lags by two samples.
        run_sweep("delay2", 2'd2, '0);
        // Start while locked resweeps.
        run_sweep("restart", 2'd2, '0);

        do_reset();
        ref_delay = 2'd0;
        run_sweep("delay0", 2'd0, '0);

        do_reset();
        ref_delay  = 2'd1;
        ref_offset = 18'sd3;
        run_sweep("offset", 2'd1, ACC_W'(3 * N));

        do_reset();
        ref_delay  = 2'd0;
        ref_offset = '0;
        const_mode = 1'b1;
        run_sweep("tie", 2'd0, '0);

        // Start during busy is ignored; reset mid cand=2 clears everything.
        do_reset();
        const_mode = 1'b0;
        ref_delay  = 2'd2;
        pulse_start(s0);
        wait_strobes("midstart", s0, 100);
        @(negedge sys_clk);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        check("midstart_busy", 64'(busy), 64'd1);
        check("midstart_dc", 64'(delay_change), 64'd0);
        wait_strobes("cand2", s0, 2 * (SETTLE + N) + 50);
        check("cand2_dc", 64'(delay_change), 64'd2);
        check("cand2_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge sys_clk);
        reset = 1'b0;
        check("midrst_delay_change", 64'(delay_change), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_locked", 64'(locked), 64'd0);
        check("midrst_best_err", 64'(best_err), 64'd0);
        repeat (3) @(negedge sys_clk);
        check("idle_busy", 64'(busy), 64'd0);
        run_sweep("fresh", 2'd2, '0);

        // Unchanged alignment keeps lock.
        s0 = strobe_cnt;
        wait_strobes("hold", s0, 300);
        check("hold_locked", 64'(locked), 64'd1);
        check("hold_dc", 64'(delay_change), 64'd2);

`ifdef TIMING_ALIGN_TRACK_EN
        begin
            exp_t e;
            int   n;
            e.dc  = 2'd3;
            e.err = '0;
            sb.push_back(e);
            ref_delay = 2'd3;
            n = 0;
            while (locked && n < 2200) begin
                @(negedge sys_clk);
                n++;
            end
            check("track_unlock", 64'(locked), 64'd0);
            check("track_busy", 64'(busy), 64'd1);
            wait_lock("track", 0, 1'b0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
